// File: rtl/icache_line_fill.sv
// -----------------------------------------------------------------------------
// icache_line_fill
//
// Instruction-cache refill controller. A fetch miss issues one line request
// to the memory bus. The in-order response beats are written into port 0 of
// the IC data SRAM as full-mask 64-bit writes. After the last beat, the
// line's {valid, tag} entry is written and fetch gets a one-cycle fill_done
// pulse. Every output is registered.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   miss_valid/addr   fetch miss request (byte address), held until accepted
//   miss_ready        high only while idle; accept = miss_valid && miss_ready
//   mem_req_valid/
//   mem_req_addr/
//   mem_req_ready     line request handshake (line-aligned byte address)
//   mem_rsp_valid/
//   mem_rsp_data      response beats, ascending word order, no backpressure
//   sram_nce/nwe      SRAM port-0 chip/write enable, active low
//   sram_addr/wdata/
//   sram_wmask        SRAM port-0 word address, data, byte mask
//   tag_we/index/
//   tag_value         tag-array write strobe, line index, {valid, tag}
//   fill_done         one-cycle pulse together with the final data/tag write
//   busy              controller is not idle
// -----------------------------------------------------------------------------
module icache_line_fill #(
    parameter  int ADDR_LEN   = 10,
    parameter  int WORD_SIZE  = 64,
    parameter  int LINE_WORDS = 8,
    parameter  int MEM_ADDR_W = 32,
    localparam int OFF_W      = $clog2(LINE_WORDS),
    localparam int IDX_W      = ADDR_LEN - OFF_W,
    localparam int TAG_W      = MEM_ADDR_W - ADDR_LEN - 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   miss_valid,
    input  logic [MEM_ADDR_W-1:0]  miss_addr,
    output logic                   miss_ready,

    output logic                   mem_req_valid,
    output logic [MEM_ADDR_W-1:0]  mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [WORD_SIZE-1:0]   mem_rsp_data,

    output logic                   sram_nce,
    output logic                   sram_nwe,
    output logic [ADDR_LEN-1:0]    sram_addr,
    output logic [WORD_SIZE-1:0]   sram_wdata,
    output logic [WORD_SIZE/8-1:0] sram_wmask,

    output logic                   tag_we,
    output logic [IDX_W-1:0]       tag_index,
    output logic [TAG_W:0]         tag_value,

    output logic                   fill_done,
    output logic                   busy
);

    // Byte-offset bits inside one line; cleared to form the request address.
    localparam logic [MEM_ADDR_W-1:0] LINE_MASK = MEM_ADDR_W'(LINE_WORDS * (WORD_SIZE / 8) - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [OFF_W-1:0] count, count_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             last_beat;

    // Next-cycle values of the registered outputs.
    logic                   miss_ready_d;
    logic                   busy_d;
    logic                   mem_req_valid_d;
    logic [MEM_ADDR_W-1:0]  mem_req_addr_d;
    logic                   sram_nce_d;
    logic                   sram_nwe_d;
    logic [ADDR_LEN-1:0]    sram_addr_d;
    logic [WORD_SIZE-1:0]   sram_wdata_d;
    logic [WORD_SIZE/8-1:0] sram_wmask_d;
    logic                   tag_we_d;
    logic [IDX_W-1:0]       tag_index_d;
    logic [TAG_W:0]         tag_value_d;
    logic                   fill_done_d;

    assign last_beat = (count == OFF_W'(LINE_WORDS - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps this purely
        // combinational; a missed branch would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (miss_valid)                 state_nxt = REQ;
            REQ:     if (mem_req_ready)              state_nxt = FILL;
            FILL:    if (mem_rsp_valid && last_beat) state_nxt = COMMIT;
            COMMIT:                                  state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        count_d         = count;
        index_d         = index_q;
        tag_d           = tag_q;
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = mem_req_addr;
        sram_nce_d      = 1'b1;
        sram_nwe_d      = 1'b1;
        sram_addr_d     = sram_addr;
        sram_wdata_d    = sram_wdata;
        sram_wmask_d    = '0;
        tag_we_d        = 1'b0;
        tag_index_d     = tag_index;
        tag_value_d     = tag_value;
        fill_done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (miss_valid) begin
                    index_d         = miss_addr[ADDR_LEN+2:OFF_W+3];
                    tag_d           = miss_addr[MEM_ADDR_W-1:ADDR_LEN+3];
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = miss_addr & ~LINE_MASK;
                    count_d         = '0;
                end
            end
            REQ: begin
                // Request stays up until the bus has taken it; any beat seen
                // here is a bus protocol violation and is dropped.
                mem_req_valid_d = !mem_req_ready;
                count_d         = '0;
            end
            FILL: begin
                if (mem_rsp_valid) begin
                    sram_nce_d   = 1'b0;
                    sram_nwe_d   = 1'b0;
                    sram_addr_d  = {index_q, count};
                    sram_wdata_d = mem_rsp_data;
                    sram_wmask_d = '1;
                    // Wraps to zero on the last beat, which also leaves FILL.
                    count_d      = count + 1'b1;
                    if (last_beat) begin
                        // Tag goes valid only together with the final word.
                        tag_we_d    = 1'b1;
                        tag_index_d = index_q;
                        tag_value_d = {1'b1, tag_q};
                        fill_done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        miss_ready_d = (state_nxt == IDLE);
        busy_d       = (state_nxt != IDLE);
    end

    // -------------------------------------------------------------------------
    // Output and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            miss_ready    <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            sram_nce      <= 1'b1;
            sram_nwe      <= 1'b1;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_wmask    <= '0;
            tag_we        <= 1'b0;
            tag_index     <= '0;
            tag_value     <= '0;
            fill_done     <= 1'b0;
        end else begin
            count         <= count_d;
            miss_ready    <= miss_ready_d;
            busy          <= busy_d;
            mem_req_valid <= mem_req_valid_d;
            mem_req_addr  <= mem_req_addr_d;
            sram_nce      <= sram_nce_d;
            sram_nwe      <= sram_nwe_d;
            sram_addr     <= sram_addr_d;
            sram_wdata    <= sram_wdata_d;
            sram_wmask    <= sram_wmask_d;
            tag_we        <= tag_we_d;
            tag_index     <= tag_index_d;
            tag_value     <= tag_value_d;
            fill_done     <= fill_done_d;
        end
    end

    // NOTE: the index/tag capture registers carry no reset; they are loaded
    // on every miss acceptance before anything reads them.
    always_ff @(posedge clk) begin
        index_q <= index_d;
        tag_q   <= tag_d;
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// -----------------------------------------------------------------------------
// tb_icache_line_fill
//
// Bench for icache_line_fill. It plays the fetch unit and the memory bus.
// A transaction-level reference model predicts every registered output from
// the inputs sampled at each clock edge. The model also keeps a reference
// image of the SRAM and tag array. At the end, that image is compared with
// the shadow image built from the writes the DUT actually made.
// -----------------------------------------------------------------------------
module tb_icache_line_fill;

    localparam int ADDR_LEN   = 10;
    localparam int WORD_SIZE  = 64;
    localparam int LINE_WORDS = 8;
    localparam int MEM_ADDR_W = 32;
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int IDX_W      = ADDR_LEN - OFF_W;
    localparam int TAG_W      = MEM_ADDR_W - ADDR_LEN - 3;
    localparam int LINE_BYTES = LINE_WORDS * WORD_SIZE / 8;

    logic                   clk;
    logic                   rst;
    logic                   miss_valid;
    logic [MEM_ADDR_W-1:0]  miss_addr;
    logic                   miss_ready;
    logic                   mem_req_valid;
    logic [MEM_ADDR_W-1:0]  mem_req_addr;
    logic                   mem_req_ready;
    logic                   mem_rsp_valid;
    logic [WORD_SIZE-1:0]   mem_rsp_data;
    logic                   sram_nce;
    logic                   sram_nwe;
    logic [ADDR_LEN-1:0]    sram_addr;
    logic [WORD_SIZE-1:0]   sram_wdata;
    logic [WORD_SIZE/8-1:0] sram_wmask;
    logic                   tag_we;
    logic [IDX_W-1:0]       tag_index;
    logic [TAG_W:0]         tag_value;
    logic                   fill_done;
    logic                   busy;

    icache_line_fill #(
        .ADDR_LEN  (ADDR_LEN),
        .WORD_SIZE (WORD_SIZE),
        .LINE_WORDS(LINE_WORDS),
        .MEM_ADDR_W(MEM_ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .sram_nce     (sram_nce),
        .sram_nwe     (sram_nwe),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_wmask   (sram_wmask),
        .tag_we       (tag_we),
        .tag_index    (tag_index),
        .tag_value    (tag_value),
        .fill_done    (fill_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Counters and checking
    // -------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: miss transaction progress and expected outputs
    // -------------------------------------------------------------------------
    typedef enum {P_IDLE, P_REQ, P_FILL, P_DONE} phase_t;

    phase_t           m_phase = P_IDLE;
    int unsigned      m_idx, m_tag, m_beats;
    bit               e_miss_ready = 1'b1, e_busy, e_req_valid, e_nce = 1'b1, e_nwe = 1'b1;
    bit               e_tag_we, e_done;
    bit [31:0]        e_req_addr;
    int unsigned      e_addr, e_tag_index;
    bit [63:0]        e_wdata;
    bit [7:0]         e_wmask;
    bit [TAG_W:0]     e_tag_value;

    bit [63:0]        ref_sram    [2**ADDR_LEN];
    bit [63:0]        shadow_sram [2**ADDR_LEN];
    bit [TAG_W:0]     ref_tag     [2**IDX_W];
    bit [TAG_W:0]     shadow_tag  [2**IDX_W];

    // Stimulus agents
    bit               want;
    bit [31:0]        want_addr;
    bit [31:0]        miss_q[$];
    bit               force_rst, rand_mode, spur_mode, alt_gap, alt_phase;
    int               stall_left, stall_pct, gap_pct, rst_permille;

    // Observation helpers
    bit               done_seen;
    int               req_valid_cycles, write_cycles;
    logic [IDX_W-1:0] done_idx[$];

    // Advance the model with the inputs sampled on this edge.
    task automatic model_update();
        int unsigned a;
        a = miss_addr;
        e_nce    = 1'b1;
        e_nwe    = 1'b1;
        e_wmask  = '0;
        e_tag_we = 1'b0;
        e_done   = 1'b0;
        if (rst) begin
            m_phase     = P_IDLE;
            e_req_valid = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (miss_valid) begin
                    m_idx       = (a / LINE_BYTES) % (2**IDX_W);
                    m_tag       = a / (2**(ADDR_LEN + 3));
                    e_req_valid = 1'b1;
                    e_req_addr  = a - (a % LINE_BYTES);
                    m_beats     = 0;
                    m_phase     = P_REQ;
                    want        = 1'b0;
                end
                P_REQ: if (mem_req_ready) begin
                    e_req_valid = 1'b0;
                    m_beats     = 0;
                    m_phase     = P_FILL;
                end
                P_FILL: if (mem_rsp_valid) begin
                    e_nce   = 1'b0;
                    e_nwe   = 1'b0;
                    e_wmask = 8'hFF;
                    e_addr  = m_idx * LINE_WORDS + m_beats;
                    e_wdata = mem_rsp_data;
                    ref_sram[e_addr] = mem_rsp_data;
                    m_beats++;
                    if (m_beats == LINE_WORDS) begin
                        e_tag_we    = 1'b1;
                        e_tag_index = m_idx;
                        e_tag_value = {1'b1, TAG_W'(m_tag)};
                        ref_tag[m_idx] = e_tag_value;
                        e_done      = 1'b1;
                        m_phase     = P_DONE;
                    end
                end
                P_DONE: m_phase = P_IDLE;
                default: ;
            endcase
        end
        e_miss_ready = (m_phase == P_IDLE);
        e_busy       = (m_phase != P_IDLE);
    endtask

    task automatic compare();
        check("miss_ready", miss_ready, e_miss_ready);
        check("busy", busy, e_busy);
        check("mem_req_valid", mem_req_valid, e_req_valid);
        if (e_req_valid) check("mem_req_addr", mem_req_addr, e_req_addr);
        check("sram_nce", sram_nce, e_nce);
        check("sram_nwe", sram_nwe, e_nwe);
        check("sram_wmask", sram_wmask, e_wmask);
        if (!e_nce) begin
            check("sram_addr", sram_addr, e_addr);
            check("sram_wdata", sram_wdata, e_wdata);
        end
        check("tag_we", tag_we, e_tag_we);
        if (e_tag_we) begin
            check("tag_index", tag_index, e_tag_index);
            check("tag_value", tag_value, e_tag_value);
        end
        check("fill_done", fill_done, e_done);
        check("nwe_without_nce", (sram_nwe === 1'b0) && (sram_nce === 1'b1), 1'b0);

        if (sram_nce === 1'b0 && sram_nwe === 1'b0 && !$isunknown(sram_addr)) begin
            shadow_sram[sram_addr] = sram_wdata;
            write_cycles++;
        end
        if (tag_we === 1'b1 && !$isunknown(tag_index)) shadow_tag[tag_index] = tag_value;
        if (fill_done === 1'b1) begin
            done_seen = 1'b1;
            done_idx.push_back(tag_index);
        end
        if (mem_req_valid === 1'b1) req_valid_cycles++;
    endtask

    // One clock: model sees the sampled inputs, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    // Choose this cycle's inputs from the fetch and memory agents.
    task automatic drive();
        rst           = force_rst || (rand_mode && $urandom_range(999) < rst_permille);
        miss_valid    = 1'b0;
        miss_addr     = $urandom;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = {$urandom, $urandom};
        if (!want) begin
            if (miss_q.size() > 0) begin
                want      = 1'b1;
                want_addr = miss_q.pop_front();
            end else if (rand_mode && $urandom_range(99) < 20) begin
                want      = 1'b1;
                want_addr = $urandom;
            end
        end
        if (want) begin
            miss_valid = 1'b1;
            miss_addr  = want_addr;
        end else if (spur_mode && m_phase != P_IDLE && $urandom_range(99) < 15) begin
            miss_valid = 1'b1;
        end
        case (m_phase)
            P_REQ: begin
                if (stall_left > 0) stall_left--;
                else mem_req_ready = ($urandom_range(99) >= stall_pct);
                if (rand_mode && $urandom_range(99) < 5) mem_rsp_valid = 1'b1;
            end
            P_FILL: begin
                if (alt_gap) begin
                    mem_rsp_valid = alt_phase;
                    alt_phase     = !alt_phase;
                end else begin
                    mem_rsp_valid = ($urandom_range(99) >= gap_pct);
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_until_done(input string tag, input int max_cycles);
        int n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < max_cycles) begin
            drive();
            step();
            n++;
        end
        if (!done_seen) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic run_until_beats(input string tag, input int unsigned beats);
        int n = 0;
        while (!(m_phase == P_FILL && m_beats == beats) && n < 100) begin
            drive();
            step();
            n++;
        end
        if (n >= 100) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        force_rst = 1'b1;
        repeat (3) begin
            drive();
            step();
        end
        force_rst = 1'b0;

        // Reset values
        check("rst_miss_ready", miss_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        check("rst_sram_nce", sram_nce, 1'b1);
        check("rst_sram_nwe", sram_nwe, 1'b1);
        check("rst_sram_addr", sram_addr, 10'h0);
        check("rst_sram_wdata", sram_wdata, 64'h0);
        check("rst_sram_wmask", sram_wmask, 8'h0);
        check("rst_tag_we", tag_we, 1'b0);
        check("rst_tag_index", tag_index, 7'h0);
        check("rst_tag_value", tag_value, 20'h0);
        check("rst_fill_done", fill_done, 1'b0);

        // Single zero-stall fill
        miss_q.push_back(32'h0000_1A48);
        drive();
        step();
        check("t1_req_addr", mem_req_addr, 32'h0000_1A40);
        check("t1_miss_ready_drop", miss_ready, 1'b0);
        run_until_done("t1", 100);
        check("t1_tag_index", tag_index, 7'h69);
        check("t1_tag_value", tag_value, 20'h8_0000);
        drive();
        step();
        check("t1_miss_ready_back", miss_ready, 1'b1);

        // Request stalled for 5 cycles
        stall_left       = 5;
        req_valid_cycles = 0;
        write_cycles     = 0;
        miss_q.push_back(32'h0001_2340);
        run_until_done("t2", 100);
        check("t2_req_hold_cycles", req_valid_cycles, 6);
        check("t2_write_count", write_cycles, LINE_WORDS);

        // Beats on alternate cycles
        alt_gap      = 1'b1;
        alt_phase    = 1'b1;
        write_cycles = 0;
        miss_q.push_back(32'h0000_3000);
        run_until_done("t3", 100);
        check("t3_write_count", write_cycles, LINE_WORDS);
        alt_gap = 1'b0;

        // Reset after three beats, then an unrelated fill
        miss_q.push_back(32'h0000_5A00);
        run_until_beats("t4", 3);
        force_rst = 1'b1;
        drive();
        step();
        force_rst = 1'b0;
        check("t4_miss_ready", miss_ready, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_sram_nce", sram_nce, 1'b1);
        drive();
        step();
        miss_q.push_back(32'h0000_6000);
        run_until_done("t4", 100);
        check("t4_line_invalid", shadow_tag[7'h68], 20'h0);

        // Miss raised while busy is held off until the fill completes
        miss_q.push_back(32'h0000_0000);
        run_until_beats("t5", 2);
        want      = 1'b1;
        want_addr = 32'h0000_2000;
        run_until_done("t5", 100);
        check("t5_pending_at_done", want, 1'b1);
        drive();
        step();
        check("t5_pending_in_commit", want, 1'b1);
        drive();
        step();
        check("t5_req_valid", mem_req_valid, 1'b1);
        check("t5_req_addr", mem_req_addr, 32'h0000_2000);
        run_until_done("t5b", 100);

        // Back-to-back misses at the bottom and top of the index range
        done_idx.delete();
        miss_q.push_back(32'h0000_0040);
        miss_q.push_back(32'h0000_3FC0);
        run_until_done("t6a", 100);
        run_until_done("t6b", 100);
        check("t6_done_pulses", done_idx.size(), 2);
        check("t6_idx0", done_idx[0], 7'h01);
        check("t6_idx1", done_idx[1], 7'h7F);

        // Randomised traffic with stalls, gaps, stray misses, illegal beats
        // in the request phase and occasional resets
        rand_mode    = 1'b1;
        spur_mode    = 1'b1;
        stall_pct    = 30;
        gap_pct      = 40;
        rst_permille = 5;
        repeat (4000) begin
            drive();
            step();
        end
        rand_mode    = 1'b0;
        spur_mode    = 1'b0;
        stall_pct    = 0;
        gap_pct      = 0;
        rst_permille = 0;
        for (int n = 0; n < 200 && (m_phase != P_IDLE || want); n++) begin
            drive();
            step();
        end
        drive();
        step();
        check("drain_busy", busy, 1'b0);

        // Final SRAM and tag images
        for (int i = 0; i < 2**ADDR_LEN; i++) check("sram_image", shadow_sram[i], ref_sram[i]);
        for (int i = 0; i < 2**IDX_W; i++) check("tag_image", shadow_tag[i], ref_tag[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
